// File: rtl/pipe_control_pkg.sv
// Shared encodings and the control bundle carried through the pipe_control
// ID/EX, EX/MEM and MEM/WB registers.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Width of the rd field in the bundle; must be at least REG_ADDR_W.
    localparam int CTRL_RD_W = 5;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_CMP    = 2'd1,
        ALU_RFUNCT = 2'd2,
        ALU_IFUNCT = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_RAM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic                 valid;
        logic                 enw;
        logic                 ramr;
        logic                 ramw;
        logic                 alusrc;
        alu_op_e              aluop;
        wb_sel_e              wbsel;
        logic                 branch;
        logic                 jump;
        logic [2:0]           funct3;
        logic [CTRL_RD_W-1:0] rd;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero,
                                          input logic lt,
                                          input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pipe_control_if.sv
// ID-stage inputs, EX flags and per-stage control outputs of pipe_control.
interface pipe_control_if #(
    parameter int REG_ADDR_W = 5,
    parameter int IMM_SEL_W  = 3
);
    logic                  IdValid;
    logic [6:0]            OPCode;
    logic [2:0]            Funct3;
    logic [REG_ADDR_W-1:0] Rs1;
    logic [REG_ADDR_W-1:0] Rs2;
    logic [REG_ADDR_W-1:0] Rd;
    logic                  Zero;
    logic                  Lt;
    logic                  LtU;

    logic [IMM_SEL_W-1:0]  IMMSel;
    logic                  ALUsrc;
    logic [1:0]            ALUOp;
    logic                  PCsrc;
    logic                  Flush;
    logic                  Stall;
    logic                  RAMW;
    logic                  RAMR;
    logic                  EnW;
    logic [1:0]            WBSel;
    logic [REG_ADDR_W-1:0] WbRd;
    logic                  Illegal;

    modport slave (
        input  IdValid, OPCode, Funct3, Rs1, Rs2, Rd, Zero, Lt, LtU,
        output IMMSel, ALUsrc, ALUOp, PCsrc, Flush, Stall, RAMW, RAMR,
               EnW, WBSel, WbRd, Illegal
    );

    modport master (
        output IdValid, OPCode, Funct3, Rs1, Rs2, Rd, Zero, Lt, LtU,
        input  IMMSel, ALUsrc, ALUOp, PCsrc, Flush, Stall, RAMW, RAMR,
               EnW, WBSel, WbRd, Illegal
    );
endinterface

// File: rtl/pipe_control_decode.sv
// Combinational RV32I opcode/funct3 decoder producing the control bundle,
// immediate format, source-register usage and an illegal flag.
module pipe_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter bit ENABLE_JUMP = 1'b1
) (
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [REG_ADDR_W-1:0] rd,
    output ctrl_t                 ctrl,
    output imm_sel_e              imm_sel,
    output logic                  uses_rs1,
    output logic                  uses_rs2,
    output logic                  illegal
);

    always_comb begin
        ctrl     = BUBBLE;
        imm_sel  = IMM_I;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;

        case (opcode)
            OP_R: begin
                ctrl.enw   = 1'b1;
                ctrl.aluop = ALU_RFUNCT;
                ctrl.wbsel = WB_ALU;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_I: begin
                ctrl.enw    = 1'b1;
                ctrl.alusrc = 1'b1;
                ctrl.aluop  = ALU_IFUNCT;
                ctrl.wbsel  = WB_ALU;
                uses_rs1    = 1'b1;
            end
            OP_LOAD: begin
                ctrl.enw    = 1'b1;
                ctrl.alusrc = 1'b1;
                ctrl.ramr   = 1'b1;
                ctrl.wbsel  = WB_RAM;
                uses_rs1    = 1'b1;
            end
            OP_STORE: begin
                ctrl.alusrc = 1'b1;
                ctrl.ramw   = 1'b1;
                imm_sel     = IMM_S;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    illegal = 1'b1;
                end else begin
                    ctrl.aluop  = ALU_CMP;
                    ctrl.branch = 1'b1;
                    imm_sel     = IMM_B;
                    uses_rs1    = 1'b1;
                    uses_rs2    = 1'b1;
                end
            end
            OP_LUI, OP_AUIPC: begin
                ctrl.enw    = 1'b1;
                ctrl.alusrc = 1'b1;
                ctrl.wbsel  = WB_ALU;
                imm_sel     = IMM_U;
            end
            OP_JAL: begin
                if (ENABLE_JUMP) begin
                    ctrl.enw    = 1'b1;
                    ctrl.alusrc = 1'b1;
                    ctrl.wbsel  = WB_PC4;
                    ctrl.jump   = 1'b1;
                    imm_sel     = IMM_J;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (ENABLE_JUMP) begin
                    ctrl.enw    = 1'b1;
                    ctrl.alusrc = 1'b1;
                    ctrl.wbsel  = WB_PC4;
                    ctrl.jump   = 1'b1;
                    uses_rs1    = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (!illegal) begin
            ctrl.valid  = 1'b1;
            ctrl.funct3 = funct3;
            ctrl.rd     = CTRL_RD_W'(rd);
        end
        // x0 is hard-wired, so a write to it is dropped at decode.
        if (rd == '0) begin
            ctrl.enw = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_control.sv
// Pipelined control unit: decodes ID, carries the bundle to WB, detects
// load-use hazards and resolves branches/jumps in EX.
module pipe_control
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter bit ENABLE_JUMP = 1'b1,
    parameter int IMM_SEL_W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    pipe_control_if.slave bus
);

    ctrl_t    dec_ctrl;
    imm_sel_e dec_imm;
    logic     dec_rs1;
    logic     dec_rs2;
    logic     dec_illegal;

    ctrl_t idex_d, idex_q;
    ctrl_t exmem_d, exmem_q;
    ctrl_t memwb_d, memwb_q;

    logic taken;
    logic flush;
    logic load_use;
    logic stall;
    logic illegal_pulse;

    pipe_decode #(
        .REG_ADDR_W (REG_ADDR_W),
        .ENABLE_JUMP(ENABLE_JUMP)
    ) u_decode (
        .opcode  (bus.OPCode),
        .funct3  (bus.Funct3),
        .rd      (bus.Rd),
        .ctrl    (dec_ctrl),
        .imm_sel (dec_imm),
        .uses_rs1(dec_rs1),
        .uses_rs2(dec_rs2),
        .illegal (dec_illegal)
    );

    always_comb begin
        taken    = branch_taken(idex_q.funct3, bus.Zero, bus.Lt, bus.LtU);
        flush    = idex_q.valid && (idex_q.jump || (idex_q.branch && taken));
        load_use = bus.IdValid && idex_q.valid && idex_q.ramr &&
                   (idex_q.rd != '0) &&
                   ((dec_rs1 && (idex_q.rd == CTRL_RD_W'(bus.Rs1))) ||
                    (dec_rs2 && (idex_q.rd == CTRL_RD_W'(bus.Rs2))));
        stall         = load_use && !flush;
        illegal_pulse = rst_n && bus.IdValid && dec_illegal && !flush && !stall;

        // A flush and a load-use stall both insert the same single bubble.
        idex_d = dec_ctrl;
        if (!bus.IdValid || dec_illegal || flush || load_use) begin
            idex_d = BUBBLE;
        end
        exmem_d = idex_q;
        memwb_d = exmem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= BUBBLE;
            exmem_q <= BUBBLE;
            memwb_q <= BUBBLE;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.IMMSel  = IMM_SEL_W'(dec_imm);
    assign bus.Stall   = stall;
    assign bus.Illegal = illegal_pulse;
    assign bus.ALUsrc  = idex_q.alusrc;
    assign bus.ALUOp   = idex_q.aluop;
    assign bus.PCsrc   = flush;
    assign bus.Flush   = flush;
    assign bus.RAMR    = exmem_q.ramr;
    assign bus.RAMW    = exmem_q.ramw;
    assign bus.EnW     = memwb_q.enw;
    assign bus.WBSel   = memwb_q.wbsel;
    assign bus.WbRd    = REG_ADDR_W'(memwb_q.rd);

    // Later stages only consume a few bundle fields.
    logic ctrl_unused;
    assign ctrl_unused = ^{exmem_q, memwb_q};

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: one DUT with jumps enabled, one without.
module tb_pipe_control;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] AUI_OP = 7'b0010111;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] BAD_OP = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_control_if #(.REG_ADDR_W(5), .IMM_SEL_W(3)) bus_j ();
    pipe_control_if #(.REG_ADDR_W(5), .IMM_SEL_W(3)) bus_n ();

    pipe_control #(.REG_ADDR_W(5), .ENABLE_JUMP(1'b1), .IMM_SEL_W(3))
        dut_j (.clk(clk), .rst_n(rst_n), .bus(bus_j));
    pipe_control #(.REG_ADDR_W(5), .ENABLE_JUMP(1'b0), .IMM_SEL_W(3))
        dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    task automatic set_id(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus_j.IdValid = v;  bus_n.IdValid = v;
        bus_j.OPCode  = op; bus_n.OPCode  = op;
        bus_j.Funct3  = f3; bus_n.Funct3  = f3;
        bus_j.Rs1 = rs1; bus_n.Rs1 = rs1;
        bus_j.Rs2 = rs2; bus_n.Rs2 = rs2;
        bus_j.Rd  = rd;  bus_n.Rd  = rd;
    endtask

    task automatic set_flags(input logic z, input logic lt, input logic ltu);
        bus_j.Zero = z; bus_n.Zero = z;
        bus_j.Lt = lt;  bus_n.Lt = lt;
        bus_j.LtU = ltu; bus_n.LtU = ltu;
    endtask

    task automatic idle();
        set_id(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        set_flags(1'b0, 1'b0, 1'b0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        idle();
        set_flags(1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        set_id(1'b1, LUI_OP, 3'd0, 5'd0, 5'd0, 5'd7);
        #1;
        n_cmp++; if ({bus_j.PCsrc, bus_j.Flush, bus_j.Stall, bus_j.RAMR, bus_j.RAMW, bus_j.EnW, bus_j.Illegal, bus_j.ALUsrc} !== 8'd0) begin n_bad++; $display("FAIL reset_flags got %b want 00000000", {bus_j.PCsrc, bus_j.Flush, bus_j.Stall, bus_j.RAMR, bus_j.RAMW, bus_j.EnW, bus_j.Illegal, bus_j.ALUsrc}); end
        n_cmp++; if ({bus_j.ALUOp, bus_j.WBSel, bus_j.WbRd} !== 9'd0) begin n_bad++; $display("FAIL reset_fields got %h want 0", {bus_j.ALUOp, bus_j.WBSel, bus_j.WbRd}); end
        n_cmp++; if (bus_j.IMMSel !== 3'd3) begin n_bad++; $display("FAIL reset_immsel got %0d want 3", bus_j.IMMSel); end
        set_id(1'b1, BAD_OP, 3'd0, 5'd0, 5'd0, 5'd1);
        #1;
        n_cmp++; if (bus_j.Illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %b want 0", bus_j.Illegal); end
        step();
        idle();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_rtype();
        set_id(1'b1, R_OP, 3'd0, 5'd1, 5'd2, 5'd3);
        #1;
        n_cmp++; if ({bus_j.Stall, bus_j.Illegal} !== 2'b00) begin n_bad++; $display("FAIL add_id got %b want 00", {bus_j.Stall, bus_j.Illegal}); end
        step(); idle(); #1;
        n_cmp++; if ({bus_j.ALUOp, bus_j.ALUsrc, bus_j.PCsrc} !== 4'b1000) begin n_bad++; $display("FAIL add_ex got %b want 1000", {bus_j.ALUOp, bus_j.ALUsrc, bus_j.PCsrc}); end
        step();
        n_cmp++; if ({bus_j.RAMR, bus_j.RAMW} !== 2'b00) begin n_bad++; $display("FAIL add_mem got %b want 00", {bus_j.RAMR, bus_j.RAMW}); end
        step();
        n_cmp++; if ({bus_j.EnW, bus_j.WBSel, bus_j.WbRd} !== {1'b1, 2'd1, 5'd3}) begin n_bad++; $display("FAIL add_wb got %b want 1_01_00011", {bus_j.EnW, bus_j.WBSel, bus_j.WbRd}); end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1'b1, LD_OP, 3'd2, 5'd1, 5'd0, 5'd5);
        #1;
        n_cmp++; if ({bus_j.IMMSel, bus_j.Stall} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL lw_id got %b want 0000", {bus_j.IMMSel, bus_j.Stall}); end
        step();
        set_id(1'b1, R_OP, 3'd0, 5'd5, 5'd1, 5'd6);
        #1;
        n_cmp++; if (bus_j.Stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %b want 1", bus_j.Stall); end
        n_cmp++; if (bus_j.ALUsrc !== 1'b1) begin n_bad++; $display("FAIL lw_ex_alusrc got %b want 1", bus_j.ALUsrc); end
        step(); #1;
        n_cmp++; if ({bus_j.Stall, bus_j.ALUOp, bus_j.ALUsrc, bus_j.RAMR} !== 5'b00001) begin n_bad++; $display("FAIL lu_bubble got %b want 00001", {bus_j.Stall, bus_j.ALUOp, bus_j.ALUsrc, bus_j.RAMR}); end
        step(); idle(); #1;
        n_cmp++; if (bus_j.ALUOp !== 2'd2) begin n_bad++; $display("FAIL lu_add_ex got %0d want 2", bus_j.ALUOp); end
        n_cmp++; if ({bus_j.EnW, bus_j.WBSel, bus_j.WbRd} !== {1'b1, 2'd0, 5'd5}) begin n_bad++; $display("FAIL lw_wb got %b want 1_00_00101", {bus_j.EnW, bus_j.WBSel, bus_j.WbRd}); end
        step();
        n_cmp++; if (bus_j.EnW !== 1'b0) begin n_bad++; $display("FAIL lu_wb_bubble got %b want 0", bus_j.EnW); end
        step();
        n_cmp++; if ({bus_j.EnW, bus_j.WBSel, bus_j.WbRd} !== {1'b1, 2'd1, 5'd6}) begin n_bad++; $display("FAIL lu_add_wb got %b want 1_01_00110", {bus_j.EnW, bus_j.WBSel, bus_j.WbRd}); end
        drain();
    endtask

    task automatic test_rd_zero();
        set_id(1'b1, LD_OP, 3'd2, 5'd1, 5'd0, 5'd0);
        step();
        set_id(1'b1, R_OP, 3'd0, 5'd0, 5'd0, 5'd0);
        #1;
        n_cmp++; if (bus_j.Stall !== 1'b0) begin n_bad++; $display("FAIL x0_no_stall got %b want 0", bus_j.Stall); end
        step(); idle(); step();
        n_cmp++; if (bus_j.EnW !== 1'b0) begin n_bad++; $display("FAIL x0_load_enw got %b want 0", bus_j.EnW); end
        step();
        n_cmp++; if (bus_j.EnW !== 1'b0) begin n_bad++; $display("FAIL x0_add_enw got %b want 0", bus_j.EnW); end
        drain();
    endtask

    task automatic test_branches();
        logic [2:0] f3_t [9] = '{3'd1, 3'd1, 3'd0, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
        logic [2:0] fl_t [9] = '{3'b000, 3'b100, 3'b100, 3'b010, 3'b000, 3'b010, 3'b001, 3'b001, 3'b000};
        logic       ex_t [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0] fl;
        for (int i = 0; i < 9; i++) begin
            set_id(1'b1, BR_OP, f3_t[i], 5'd1, 5'd2, 5'd0);
            #1;
            n_cmp++; if (bus_j.IMMSel !== 3'd2) begin n_bad++; $display("FAIL br%0d_immsel got %0d want 2", i, bus_j.IMMSel); end
            step(); idle();
            fl = fl_t[i];
            set_flags(fl[2], fl[1], fl[0]);
            #1;
            n_cmp++; if ({bus_j.PCsrc, bus_j.Flush, bus_j.ALUOp} !== {ex_t[i], ex_t[i], 2'd1}) begin n_bad++; $display("FAIL br%0d_f3_%0d got %b want %b%b01", i, f3_t[i], {bus_j.PCsrc, bus_j.Flush, bus_j.ALUOp}, ex_t[i], ex_t[i]); end
            step();
            n_cmp++; if (bus_j.PCsrc !== 1'b0) begin n_bad++; $display("FAIL br%0d_oneshot got %b want 0", i, bus_j.PCsrc); end
            set_flags(1'b0, 1'b0, 1'b0);
        end
        set_id(1'b1, BR_OP, 3'd2, 5'd1, 5'd2, 5'd0);
        #1;
        n_cmp++; if (bus_j.Illegal !== 1'b1) begin n_bad++; $display("FAIL br_f3_010_illegal got %b want 1", bus_j.Illegal); end
        step(); idle(); set_flags(1'b1, 1'b1, 1'b1); #1;
        n_cmp++; if ({bus_j.PCsrc, bus_j.ALUOp} !== 3'b000) begin n_bad++; $display("FAIL br_f3_010_bubble got %b want 000", {bus_j.PCsrc, bus_j.ALUOp}); end
        drain();
    endtask

    task automatic test_flush_vs_stall();
        set_id(1'b1, BR_OP, 3'd0, 5'd1, 5'd2, 5'd0);
        step();
        set_id(1'b1, LD_OP, 3'd2, 5'd1, 5'd0, 5'd5);
        set_flags(1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++; if ({bus_j.Flush, bus_j.Stall} !== 2'b10) begin n_bad++; $display("FAIL fl_beq got %b want 10", {bus_j.Flush, bus_j.Stall}); end
        step();
        set_flags(1'b0, 1'b0, 1'b0);
        set_id(1'b1, R_OP, 3'd0, 5'd5, 5'd1, 5'd6);
        #1;
        n_cmp++; if ({bus_j.Flush, bus_j.Stall} !== 2'b00) begin n_bad++; $display("FAIL fl_no_stall got %b want 00", {bus_j.Flush, bus_j.Stall}); end
        step(); idle(); #1;
        n_cmp++; if ({bus_j.ALUOp, bus_j.RAMR} !== 3'b100) begin n_bad++; $display("FAIL fl_single_bubble got %b want 100", {bus_j.ALUOp, bus_j.RAMR}); end
        drain();
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, BR_OP, 3'd0, 5'd1, 5'd2, 5'd0);
        step();
        set_flags(1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus_j.PCsrc !== 1'b1) begin n_bad++; $display("FAIL b2b_first got %b want 1", bus_j.PCsrc); end
        step(); idle(); #1;
        n_cmp++; if (bus_j.PCsrc !== 1'b0) begin n_bad++; $display("FAIL b2b_second got %b want 0", bus_j.PCsrc); end
        set_flags(1'b0, 1'b0, 1'b0);
        set_id(1'b1, BR_OP, 3'd1, 5'd1, 5'd2, 5'd0);
        step();
        set_id(1'b1, BAD_OP, 3'd0, 5'd0, 5'd0, 5'd1);
        #1;
        n_cmp++; if ({bus_j.Flush, bus_j.Illegal} !== 2'b10) begin n_bad++; $display("FAIL ill_under_flush got %b want 10", {bus_j.Flush, bus_j.Illegal}); end
        drain();
    endtask

    task automatic test_jal();
        set_id(1'b1, JAL_OP, 3'd0, 5'd0, 5'd0, 5'd1);
        #1;
        n_cmp++; if ({bus_j.IMMSel, bus_j.Illegal} !== {3'd4, 1'b0}) begin n_bad++; $display("FAIL jal_id got %b want 1000", {bus_j.IMMSel, bus_j.Illegal}); end
        n_cmp++; if (bus_n.Illegal !== 1'b1) begin n_bad++; $display("FAIL nojump_illegal got %b want 1", bus_n.Illegal); end
        step(); idle(); #1;
        n_cmp++; if ({bus_j.PCsrc, bus_j.Flush} !== 2'b11) begin n_bad++; $display("FAIL jal_ex got %b want 11", {bus_j.PCsrc, bus_j.Flush}); end
        n_cmp++; if (bus_n.PCsrc !== 1'b0) begin n_bad++; $display("FAIL nojump_pcsrc got %b want 0", bus_n.PCsrc); end
        step(); step();
        n_cmp++; if ({bus_j.EnW, bus_j.WBSel, bus_j.WbRd} !== {1'b1, 2'd2, 5'd1}) begin n_bad++; $display("FAIL jal_wb got %b want 1_10_00001", {bus_j.EnW, bus_j.WBSel, bus_j.WbRd}); end
        n_cmp++; if (bus_n.EnW !== 1'b0) begin n_bad++; $display("FAIL nojump_enw got %b want 0", bus_n.EnW); end
        drain();
    endtask

    task automatic test_formats();
        set_id(1'b1, AUI_OP, 3'd0, 5'd0, 5'd0, 5'd2);
        #1;
        n_cmp++; if (bus_j.IMMSel !== 3'd3) begin n_bad++; $display("FAIL auipc_immsel got %0d want 3", bus_j.IMMSel); end
        set_id(1'b1, ST_OP, 3'd2, 5'd1, 5'd2, 5'd0);
        #1;
        n_cmp++; if (bus_j.IMMSel !== 3'd1) begin n_bad++; $display("FAIL store_immsel got %0d want 1", bus_j.IMMSel); end
        set_id(1'b1, BAD_OP, 3'd0, 5'd0, 5'd0, 5'd1);
        #1;
        n_cmp++; if (bus_j.Illegal !== 1'b1) begin n_bad++; $display("FAIL bad_op_illegal got %b want 1", bus_j.Illegal); end
        bus_j.IdValid = 1'b0;
        #1;
        n_cmp++; if (bus_j.Illegal !== 1'b0) begin n_bad++; $display("FAIL bad_op_invalid got %b want 0", bus_j.Illegal); end
        set_id(1'b1, I_OP, 3'd0, 5'd1, 5'd0, 5'd4);
        step(); idle(); #1;
        n_cmp++; if ({bus_j.ALUsrc, bus_j.ALUOp} !== 3'b111) begin n_bad++; $display("FAIL addi_ex got %b want 111", {bus_j.ALUsrc, bus_j.ALUOp}); end
        drain();
    endtask

    task automatic test_async_reset();
        set_id(1'b1, ST_OP, 3'd2, 5'd1, 5'd2, 5'd0);
        step(); idle(); #1;
        n_cmp++; if ({bus_j.ALUsrc, bus_j.ALUOp} !== 3'b100) begin n_bad++; $display("FAIL sw_ex got %b want 100", {bus_j.ALUsrc, bus_j.ALUOp}); end
        step();
        n_cmp++; if (bus_j.RAMW !== 1'b1) begin n_bad++; $display("FAIL sw_mem got %b want 1", bus_j.RAMW); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_j.RAMW !== 1'b0) begin n_bad++; $display("FAIL async_ramw got %b want 0", bus_j.RAMW); end
        set_id(1'b1, R_OP, 3'd0, 5'd1, 5'd2, 5'd3);
        step();
        n_cmp++; if (bus_j.ALUOp !== 2'd0) begin n_bad++; $display("FAIL rst_hold_aluop got %0d want 0", bus_j.ALUOp); end
        idle();
        #1 rst_n = 1'b1;
        step(); step(); step();
        n_cmp++; if ({bus_j.ALUsrc, bus_j.ALUOp, bus_j.RAMW, bus_j.RAMR, bus_j.EnW, bus_j.PCsrc} !== 7'd0) begin n_bad++; $display("FAIL post_rst_bubble got %b want 0", {bus_j.ALUsrc, bus_j.ALUOp, bus_j.RAMW, bus_j.RAMR, bus_j.EnW, bus_j.PCsrc}); end
        set_id(1'b1, I_OP, 3'd0, 5'd1, 5'd0, 5'd9);
        step(); idle(); #1;
        n_cmp++; if ({bus_j.ALUsrc, bus_j.ALUOp} !== 3'b111) begin n_bad++; $display("FAIL post_rst_first got %b want 111", {bus_j.ALUsrc, bus_j.ALUOp}); end
        drain();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_use();
        test_rd_zero();
        test_branches();
        test_flush_vs_stall();
        test_back_to_back();
        test_jal();
        test_formats();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
